cfa_window_5x5: RTL



---
 rtl/cfa_window_5x5.sv | 114 +++++++++++
 1 files changed

// File: rtl/cfa_window_5x5.sv
// 5x5 CFA neighbourhood window generator: four line buffers feed a 5x5 register array.
// Optional macro WIN_OUT_REG_EN adds one output register stage, giving 2-cycle latency.
module cfa_window_5x5 #(
  parameter int pixelBitWidth = 12,
  parameter int IMG_WIDTH     = 640,
  parameter int IMG_HEIGHT    = 480,
  parameter int COL_W         = 10,
  parameter int ROW_W         = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sof,
  input  logic                         pix_valid,
  input  logic [pixelBitWidth-1:0]     pix_in,
  output logic [25*pixelBitWidth-1:0]  window,
  output logic                         win_valid,
  output logic                         frame_done,
  output logic                         sof_err
);
  localparam int PW = pixelBitWidth;

  // Stream has no backpressure: a pixel is taken on every cycle pix_valid=1,
  // and each output strobe is a single-cycle pulse with no ready.

  logic [COL_W-1:0] col, cur_col;
  logic [ROW_W-1:0] row, cur_row;
  logic             at_origin, last_col, last_row, interior;

  logic [PW-1:0]    lb  [4][IMG_WIDTH];
  logic [PW-1:0]    tap [4];
  logic [PW-1:0]    win [5][5];

  logic [25*PW-1:0] window_s;
  logic             win_valid_s, frame_done_s, sof_err_s;

  // sof forces the incoming pixel to (0,0) regardless of the counters.
  always_comb begin
    cur_col   = sof ? '0 : col;
    cur_row   = sof ? '0 : row;
    at_origin = (col == '0) && (row == '0);
    last_col  = (cur_col == COL_W'(IMG_WIDTH - 1));
    last_row  = (cur_row == ROW_W'(IMG_HEIGHT - 1));
    interior  = (cur_row >= ROW_W'(4)) && (cur_col >= COL_W'(4));
    for (int n = 0; n < 4; n++) tap[n] = lb[n][cur_col];
  end

  // Line buffers are not reset; stale rows never reach a valid window.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb[0][cur_col] <= pix_in;
      for (int n = 1; n < 4; n++) lb[n][cur_col] <= tap[n-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col          <= '0;
      row          <= '0;
      win_valid_s  <= 1'b0;
      frame_done_s <= 1'b0;
      sof_err_s    <= 1'b0;
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) win[i][j] <= '0;
    end else begin
      win_valid_s  <= pix_valid && interior;
      frame_done_s <= pix_valid && last_col && last_row;
      sof_err_s    <= pix_valid && sof && !at_origin;
      if (pix_valid) begin
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 4; j++) win[i][j] <= win[i][j+1];
        win[0][4] <= tap[3];
        win[1][4] <= tap[2];
        win[2][4] <= tap[1];
        win[3][4] <= tap[0];
        win[4][4] <= pix_in;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
      end
    end
  end

  always_comb begin
    window_s = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) window_s[(5*i+j)*PW +: PW] = win[i][j];
  end

`ifdef WIN_OUT_REG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window     <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      window     <= window_s;
      win_valid  <= win_valid_s;
      frame_done <= frame_done_s;
      sof_err    <= sof_err_s;
    end
  end
`else
  assign window     = window_s;
  assign win_valid  = win_valid_s;
  assign frame_done = frame_done_s;
  assign sof_err    = sof_err_s;
`endif

endmodule
